grf_bypass_sb: RTL
==================

Name: grf_bypass_sb

Overview:
- Parametrised general-purpose register file for the pipelined MIPS core. Successor to the single-cycle GRF.
- Generalised in data width, register count and number of read ports.
- Adds write-to-read bypass, so the pipeline no longer needs a separate W→D forwarding mux.
- Adds a per-register pending scoreboard, which the hazard unit uses for stall decisions.

Parameters:
- DATA_W, 32, data width of each register.
- ADDR_W, 5, register address width; depth = 2**ADDR_W.
- NRD, 2, number of independent read ports (1..4).
- CNT_W, 32, width of the retired-write counter.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset, synchronous, active-high.
- rd_addr  in  NRD*ADDR_W  read addresses; port k uses bits [k*ADDR_W +: ADDR_W].
- rd_data  out  NRD*DATA_W  read data; port k uses bits [k*DATA_W +: DATA_W].
- rd_pending  out  NRD  port k's register has an outstanding producer.
- we  in  1  write enable.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write data.
- wr_pc  in  32  PC of the writing instruction, used only for trace.
- issue_en  in  1  mark a register as having an in-flight producer.
- issue_addr  in  ADDR_W  register to mark.
- wr_count  out  CNT_W  number of committed writes to non-zero registers.

Behaviour:
- Storage:
  - 2**ADDR_W registers, each DATA_W wide.
  - pend bit vector, 2**ADDR_W bits.
  - wr_count register.
- Reset (rst=1 at posedge): all registers, all pend bits and wr_count go to 0. rst has priority over we and issue_en in the same cycle. Reset asserted mid-stream discards any write or issue presented in that cycle.
- Register 0:
  - Reads always return 0.
  - Writes to it are ignored and do not increment wr_count.
  - issue to it is ignored; pend[0] is always 0.
- Write: on posedge with we=1, wr_addr!=0 and rst=0:
  - reg[wr_addr] <= wr_data.
  - wr_count <= wr_count+1, wrapping modulo 2**CNT_W.
- Read (combinational, zero latency), for each port k:
  - If rd_addr_k==0, rd_data_k=0.
  - Else if we=1 and wr_addr==rd_addr_k, rd_data_k=wr_data (bypass: new value visible in the same cycle).
  - Else rd_data_k=reg[rd_addr_k].
- Scoreboard update at posedge, with rst=0:
  - issue_en=1 and issue_addr!=0: pend[issue_addr] <= 1.
  - we=1 and wr_addr!=0: pend[wr_addr] <= 0.
  - Same address in the same cycle: issue wins and the bit stays 1 (a new producer is issued as the old one retires).
  - Different addresses: both updates apply.
- rd_pending_k:
  - Equals pend[rd_addr_k] & ~(we & wr_addr==rd_addr_k).
  - The clear is bypassed, so a consumer sees the producer resolved in the cycle the write happens.
  - Always 0 when rd_addr_k==0.
- Multiple read ports may address the same register; each gets identical data and pending values.
- No other internal state; there is no latency beyond the combinational read.

Optional Feature:
- Macro GRF_TRACE_EN.
- Defined: each committed write (conditions as in Write) executes $display("@%h: $%d <= %h", wr_pc, wr_addr, wr_data) at that posedge.
- Not defined: no display statements are compiled, and wr_pc is unused. Functional behaviour is identical in both cases.

Test Plan:
- Reset clear: write 0x1234 to $5, assert rst one cycle → $5 reads 0, rd_pending=0, wr_count=0.
- Zero register: we=1, wr_addr=0, wr_data=0xFFFFFFFF, issue to $0 → reads of $0 return 0, rd_pending=0, wr_count unchanged.
- Bypass: reg $8=0xAAAA; in one cycle we=1, wr_addr=8, wr_data=0x5555 with rd_addr port0=8 → rd_data0=0x5555 in that same cycle; next cycle it reads 0x5555 from storage.
- Scoreboard: issue $3 at cycle t → rd_pending for $3 is 1 from t+1. Write $3 at t+3 → rd_pending=0 during t+3 (bypassed) and stays 0 afterwards.
- Simultaneous issue+write to $9 with pend[9]=1 → pend[9] remains 1. With issue $9 and write $10 in the same cycle → pend[9]=1, pend[10]=0.
- NRD=3, all ports reading $4=0xCAFE, plus wrap: CNT_W=4 with 16 writes → all three rd_data=0xCAFE; wr_count returns to 0.

Source files
------------

// File: rtl/grf_bypass_sb.sv
//==============================================================================
// Module      : grf_bypass_sb
// Description : Parametrised MIPS register file with write-to-read bypass and
//               per-register pending scoreboard. Optional write trace under
//               the GRF_TRACE_EN macro.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module grf_bypass_sb #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int NRD    = 2,
   parameter int CNT_W  = 32
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NRD*ADDR_W-1:0]   rd_addr,
   output logic [NRD*DATA_W-1:0]   rd_data,
   output logic [NRD-1:0]          rd_pending,
   input  logic                    we,
   input  logic [ADDR_W-1:0]       wr_addr,
   input  logic [DATA_W-1:0]       wr_data,
   input  logic [31:0]             wr_pc,
   input  logic                    issue_en,
   input  logic [ADDR_W-1:0]       issue_addr,
   output logic [CNT_W-1:0]        wr_count
);

   localparam int c_DEPTH = 2**ADDR_W;

   logic [DATA_W-1:0]  r_regs [c_DEPTH];
   logic [c_DEPTH-1:0] r_pend;
   logic [CNT_W-1:0]   r_wr_count;

   logic w_wr_commit;
   logic w_issue;

   assign w_wr_commit = we && (wr_addr != '0);
   assign w_issue     = issue_en && (issue_addr != '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < c_DEPTH; i++) begin
            r_regs[i] <= '0;
         end
         r_pend     <= '0;
         r_wr_count <= '0;
      end else begin
         if (w_wr_commit) begin
            r_regs[wr_addr]  <= wr_data;
            r_pend[wr_addr]  <= 1'b0;
            r_wr_count       <= r_wr_count + CNT_W'(1);
         end
         // Issue is applied after the clear so a same-address issue keeps the bit set.
         if (w_issue) begin
            r_pend[issue_addr] <= 1'b1;
         end
      end
   end

   assign wr_count = r_wr_count;

   generate
      for (genvar k = 0; k < NRD; k++) begin : g_rd
         logic [ADDR_W-1:0] w_addr;
         logic              w_nonzero;
         logic              w_hit;

         assign w_addr    = rd_addr[k*ADDR_W +: ADDR_W];
         assign w_nonzero = (w_addr != '0);
         assign w_hit     = we && (wr_addr == w_addr);

         always_comb begin
            rd_data[k*DATA_W +: DATA_W] = '0;
            if (w_nonzero) begin
               rd_data[k*DATA_W +: DATA_W] = w_hit ? wr_data : r_regs[w_addr];
            end
         end

         // The retiring write's clear is visible to consumers in the same cycle.
         assign rd_pending[k] = w_nonzero & r_pend[w_addr] & ~w_hit;
      end
   endgenerate

`ifdef GRF_TRACE_EN
   always_ff @(posedge clk) begin
      if (!rst && w_wr_commit) begin
         $display("@%h: $%d <= %h", wr_pc, wr_addr, wr_data);
      end
   end
`else
   logic w_unused_pc;
   assign w_unused_pc = ^wr_pc;
`endif

endmodule

`default_nettype wire
